sipo_read_gather: RTL and testbench
===================================

Name: sipo_read_gather

Overview:
Read-side counterpart of the activation buffer's parallel-write queue. It accepts one parallel read request of up to numParallelOut lane addresses and serializes them onto the single buffer read port, one address per cycle. In-order read responses are gathered back into a parallel output word. It sits between the activation buffer read port and the PE-array input lanes.

Parameters:
numParallelOut, 8, number of parallel lanes per request
readInterfaceWidth, 32, data bits per lane/read word
readAddrWidth, 16, buffer address width
maxOutstanding, 4, max issued-but-unanswered reads (≥1)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
req_valid  in  1  parallel request valid
req_ready  out  1  block can accept request
req_addr  in  numParallelOut×readAddrWidth  per-lane read address
req_mask  in  numParallelOut  lanes to read
mem_ren  out  1  read request to buffer
mem_addr  out  readAddrWidth  read address
mem_ready  in  1  buffer accepts mem_ren this cycle
mem_rvalid  in  1  read data valid (in issue order, latency ≥1)
mem_rdata  in  readInterfaceWidth  read data
out_valid  out  1  gathered word valid
out_ready  in  1  consumer accepts word
data_out  out  numParallelOut×readInterfaceWidth  gathered lane data
mask_out  out  numParallelOut  lanes filled (= accepted req_mask)

Behaviour:
- Reset (async, nrst low): state IDLE; req_ready=1, mem_ren=0, mem_addr=0, out_valid=0, data_out=0, mask_out=0; outstanding count and lane pointers cleared. Reset mid-transaction discards everything; late mem_rvalid after reset with outstanding=0 is ignored.
- FSM: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, register req_addr/req_mask, clear data_out to 0, set mask_out=req_mask. Next state is ISSUE, or DONE directly if req_mask==0.
- ISSUE: mem_ren=1 iff outstanding<maxOutstanding; mem_addr=registered addr of the lowest-index unissued active lane.
  - Issue occurs on mem_ren&&mem_ready: advance issue pointer to the next set mask bit, outstanding+1.
  - mem_ren/mem_addr are held stable while mem_ready=0.
  - After the last active lane issues, go to DRAIN.
- Response (ISSUE or DRAIN): mem_rvalid with outstanding>0 writes mem_rdata into the lowest-index active lane not yet answered, then outstanding−1. mem_rvalid with outstanding==0 is ignored.
  - Simultaneous issue and response in one cycle: outstanding unchanged.
- DRAIN: mem_ren=0. When the final response arrives, go to DONE next cycle.
- DONE: out_valid=1; data_out/mask_out held stable until out_valid&&out_ready, then IDLE (req_ready=1 next cycle).
- Masked-off lanes in data_out read 0.
- Minimum latency for k active lanes at full throughput with read latency L:
  - first mem_ren 1 cycle after accept;
  - out_valid rises 1 cycle after the last rvalid.
- Throughput is one issue per cycle while outstanding<maxOutstanding.
- req_ready=0 outside IDLE; requests are never queued.
- Counters are sized $clog2(maxOutstanding+1); lane pointers are sized $clog2(numParallelOut).

Decomposition:
- Shared package act_buf_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - lane-index width constant/function.
- Sub-module next_lane_finder: combinational lowest-set-bit-at-or-above-pointer search over the mask, returning index and found flag. Instantiated twice, once for the issue pointer and once for the response pointer.

Test Plan:
- Full mask, mem_ready=1, latency 1: mask 0xFF, addrs 0x10..0x17, rdata=addr+0x100 → mem_addr 0x10..0x17 on consecutive cycles; data_out lane i=0x110+i; mask_out=0xFF.
- Sparse mask 0b1010_0101, latency 3 → issues only lanes 0,2,5,7 in order; lanes 1,3,4,6 read 0; out_valid 1 cycle after 4th rvalid.
- Backpressure: maxOutstanding=4, latency 6, full mask → mem_ren drops after 4 issues until first rvalid; mem_ready toggled low holds mem_addr stable; all 8 lanes correct.
- Empty mask req_mask=0 → no mem_ren; out_valid the cycle after accept, mask_out=0; out_ready held low 5 cycles → outputs stable, req_ready=0 throughout.
- Reset mid-DRAIN with 2 outstanding → all outputs at reset values; the following 2 stray rvalids are ignored; a new request completes correctly.
- Spurious mem_rvalid in IDLE → no state or data change.

Source files
------------

// File: rtl/act_buf_pkg.sv
// Shared types and helpers for the activation buffer datapath.
// Holds the read-gather FSM encoding and the lane index sizing rule.
package act_buf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A single lane still needs one bit to hold index zero.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/next_lane_finder.sv
// Finds the lowest set mask bit whose index is at or above ptr.
// Purely combinational; found is low when no such bit exists.
module next_lane_finder
   import act_buf_pkg::*;
#(
   parameter int numLanes  = 8,
   parameter int laneWidth = lane_w(numLanes)
) (
   input  logic [numLanes-1:0]  mask,
   input  logic [laneWidth-1:0] ptr,
   output logic [laneWidth-1:0] idx,
   output logic                 found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Descending scan so the lowest qualifying lane wins.
      for (int i = numLanes - 1; i >= 0; i--) begin
         if (mask[i] && (laneWidth'(i) >= ptr)) begin
            idx   = laneWidth'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sipo_read_gather.sv
// Serializes one parallel read request onto the buffer read port
// and gathers the in-order responses back into a parallel word.
module sipo_read_gather
   import act_buf_pkg::*;
#(
   parameter int numParallelOut     = 8,
   parameter int readInterfaceWidth = 32,
   parameter int readAddrWidth      = 16,
   parameter int maxOutstanding     = 4
) (
   input  logic                                         clk,
   input  logic                                         nrst,
   input  logic                                         req_valid,
   output logic                                         req_ready,
   input  logic [numParallelOut*readAddrWidth-1:0]      req_addr,
   input  logic [numParallelOut-1:0]                    req_mask,
   output logic                                         mem_ren,
   output logic [readAddrWidth-1:0]                     mem_addr,
   input  logic                                         mem_ready,
   input  logic                                         mem_rvalid,
   input  logic [readInterfaceWidth-1:0]                mem_rdata,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [numParallelOut*readInterfaceWidth-1:0] data_out,
   output logic [numParallelOut-1:0]                    mask_out
);

   localparam int NP = numParallelOut;
   localparam int DW = readInterfaceWidth;
   localparam int AW = readAddrWidth;
   localparam int LW = lane_w(NP);
   localparam int CW = $clog2(maxOutstanding + 1);

   state_t state;
   state_t state_n;

   logic [NP*AW-1:0] addr_q;
   logic [NP-1:0]    mask_q;
   logic [NP*DW-1:0] data_q;
   logic [LW-1:0]    iss_ptr;
   logic [LW-1:0]    rsp_ptr;
   logic [LW-1:0]    iss_idx;
   logic [LW-1:0]    rsp_idx;
   logic             iss_found;
   logic             rsp_found;
   logic [CW-1:0]    outst;

   logic accept;
   logic issue;
   logic resp;
   logic iss_last;
   logic rsp_last;
   logic busy;

   next_lane_finder #(
      .numLanes  (NP),
      .laneWidth (LW)
   ) u_iss_find (
      .mask  (mask_q),
      .ptr   (iss_ptr),
      .idx   (iss_idx),
      .found (iss_found)
   );

   next_lane_finder #(
      .numLanes  (NP),
      .laneWidth (LW)
   ) u_rsp_find (
      .mask  (mask_q),
      .ptr   (rsp_ptr),
      .idx   (rsp_idx),
      .found (rsp_found)
   );

   // Last lane: no active mask bit above the selected index.
   assign iss_last = ((mask_q >> iss_idx) >> 1) == '0;
   assign rsp_last = ((mask_q >> rsp_idx) >> 1) == '0;

   assign busy   = (state == ISSUE) || (state == DRAIN);
   assign accept = req_valid && req_ready;
   assign issue  = mem_ren && mem_ready;
   assign resp   = busy && mem_rvalid && (outst != '0) && rsp_found;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      mem_ren   = 1'b0;
      mem_addr  = '0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_n = (req_mask == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            mem_ren  = iss_found && (outst < CW'(maxOutstanding));
            mem_addr = addr_q[iss_idx*AW +: AW];
            if (issue && iss_last) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (resp && rsp_last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         addr_q  <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         iss_ptr <= '0;
         rsp_ptr <= '0;
         outst   <= '0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            mask_q  <= req_mask;
            data_q  <= '0;
            iss_ptr <= '0;
            rsp_ptr <= '0;
            outst   <= '0;
         end
         // Pointer may wrap after the top lane; the FSM has left ISSUE/DRAIN by then.
         if (issue) begin
            iss_ptr <= iss_idx + LW'(1);
         end
         if (resp) begin
            data_q[rsp_idx*DW +: DW] <= mem_rdata;
            rsp_ptr                  <= rsp_idx + LW'(1);
         end
         case ({issue, resp})
            2'b10:   outst <= outst + CW'(1);
            2'b01:   outst <= outst - CW'(1);
            default: outst <= outst;
         endcase
      end
   end

   assign data_out = data_q;
   assign mask_out = mask_q;

endmodule

// File: tb/tb_sipo_read_gather.sv
// Directed bench for sipo_read_gather with an in-order buffer model.
// Each task drives one scenario and checks against hand-computed values.
module tb_sipo_read_gather;

   logic         clk;
   logic         nrst;
   logic         req_valid;
   logic         req_ready;
   logic [127:0] req_addr;
   logic [7:0]   req_mask;
   logic         mem_ren;
   logic [15:0]  mem_addr;
   logic         mem_ready;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] data_out;
   logic [7:0]   mask_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int lat = 1;
   bit tog = 0;
   bit inject = 0;

   typedef struct packed {
      logic [15:0] a;
      int          due;
   } rd_t;

   rd_t         q[$];
   logic [15:0] iss_log[$];
   int          iss_cyc[$];
   int          last_rv = 0;
   int          max_outs = 0;
   int          ren_over = 0;
   int          stab_viol = 0;
   int          hold_cnt = 0;
   bit          hold = 0;
   logic [15:0] hold_addr = '0;

   sipo_read_gather dut (
      .clk        (clk),
      .nrst       (nrst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_mask   (req_mask),
      .mem_ren    (mem_ren),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .mask_out   (mask_out)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = tog ? (cyc % 3 != 0) : 1'b1;
      end
   end

   // Buffer model: responses in issue order, latency lat cycles.
   initial begin
      int outs;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         outs = q.size();
         if (outs > max_outs) max_outs = outs;
         if (inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            inject     = 0;
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'(q[0].a) + 32'h100;
            last_rv    = cyc;
            void'(q.pop_front());
         end else begin
            mem_rvalid = 1'b0;
         end
         if (nrst && mem_ren) begin
            if (outs >= 4) ren_over++;
            if (hold && mem_addr !== hold_addr) stab_viol++;
         end else if (hold) begin
            stab_viol++;
         end
         hold      = nrst && mem_ren && !mem_ready;
         hold_addr = mem_addr;
         if (hold) hold_cnt++;
         if (nrst && mem_ren && mem_ready) begin
            q.push_back('{a: mem_addr, due: cyc + lat});
            iss_log.push_back(mem_addr);
            iss_cyc.push_back(cyc);
         end
      end
   end

   function automatic logic [255:0] exp_data(input logic [7:0] m,
                                             input logic [15:0] base);
      logic [255:0] v;
      logic [15:0]  a;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         a = base + 16'(i);
         if (m[i]) v[i*32 +: 32] = 32'(a) + 32'h100;
      end
      return v;
   endfunction

   task automatic clr_log();
      @(posedge clk);
      #1;
      iss_log.delete();
      iss_cyc.delete();
      max_outs  = 0;
      ren_over  = 0;
      stab_viol = 0;
      hold_cnt  = 0;
   endtask

   task automatic do_req(input logic [7:0] m, input logic [15:0] base);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_mask  = m;
      for (int i = 0; i < 8; i++) req_addr[i*16 +: 16] = base + 16'(i);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
   endtask

   task automatic wait_out(output int c, output bit ok);
      ok = 0;
      c  = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            c  = cyc;
            break;
         end
      end
   endtask

   task automatic take_out();
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, mem_ren, mem_addr, out_valid, mask_out} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}
          || data_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs rdy=%b ren=%b addr=%h ov=%b mask=%h required 1 0 0 0 0",
                  req_ready, mem_ren, mem_addr, out_valid, mask_out);
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_full();
      int oc;
      bit ok;
      lat = 1;
      tog = 0;
      clr_log();
      do_req(8'hFF, 16'h0010);
      wait_out(oc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_timeout out_valid=0 required 1");
      end
      checks++;
      if (iss_log.size() != 8) begin
         errors++;
         $display("FAIL full_issue_count got %0d required 8", iss_log.size());
      end
      for (int i = 0; i < iss_log.size() && i < 8; i++) begin
         checks++;
         if (iss_log[i] !== 16'(16'h10 + i)) begin
            errors++;
            $display("FAIL full_issue_addr[%0d] got %h required %h", i, iss_log[i], 16'(16'h10 + i));
         end
      end
      if (iss_cyc.size() == 8) begin
         checks++;
         if (iss_cyc[0] != acc_cyc || iss_cyc[7] != acc_cyc + 7) begin
            errors++;
            $display("FAIL full_issue_timing first=%0d last=%0d required %0d %0d",
                     iss_cyc[0], iss_cyc[7], acc_cyc, acc_cyc + 7);
         end
      end
      checks++;
      if (oc != last_rv + 1) begin
         errors++;
         $display("FAIL full_out_latency got cycle %0d required %0d", oc, last_rv + 1);
      end
      checks++;
      if (data_out !== exp_data(8'hFF, 16'h0010)) begin
         errors++;
         $display("FAIL full_data got %h required %h", data_out, exp_data(8'hFF, 16'h0010));
      end
      checks++;
      if (mask_out !== 8'hFF) begin
         errors++;
         $display("FAIL full_mask got %h required ff", mask_out);
      end
      take_out();
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_return_idle rdy=%b ov=%b required 1 0", req_ready, out_valid);
      end
   endtask

   task automatic test_sparse();
      int oc;
      bit ok;
      logic [15:0] ea [4];
      ea  = '{16'h20, 16'h22, 16'h25, 16'h27};
      lat = 3;
      tog = 0;
      clr_log();
      do_req(8'hA5, 16'h0020);
      wait_out(oc, ok);
      checks++;
      if (!ok || iss_log.size() != 4) begin
         errors++;
         $display("FAIL sparse_issue_count got %0d ok=%0d required 4", iss_log.size(), ok);
      end
      for (int i = 0; i < iss_log.size() && i < 4; i++) begin
         checks++;
         if (iss_log[i] !== ea[i]) begin
            errors++;
            $display("FAIL sparse_issue_addr[%0d] got %h required %h", i, iss_log[i], ea[i]);
         end
      end
      checks++;
      if (oc != last_rv + 1) begin
         errors++;
         $display("FAIL sparse_out_latency got cycle %0d required %0d", oc, last_rv + 1);
      end
      checks++;
      if (data_out !== exp_data(8'hA5, 16'h0020) || mask_out !== 8'hA5) begin
         errors++;
         $display("FAIL sparse_data got %h/%h required %h/a5",
                  data_out, mask_out, exp_data(8'hA5, 16'h0020));
      end
      take_out();
   endtask

   task automatic test_backpressure();
      int oc;
      bit ok;
      lat = 6;
      tog = 1;
      clr_log();
      do_req(8'hFF, 16'h0030);
      wait_out(oc, ok);
      tog = 0;
      checks++;
      if (!ok || iss_log.size() != 8) begin
         errors++;
         $display("FAIL bp_issue_count got %0d ok=%0d required 8", iss_log.size(), ok);
      end
      checks++;
      if (ren_over != 0 || max_outs != 4) begin
         errors++;
         $display("FAIL bp_outstanding over=%0d max=%0d required 0 4", ren_over, max_outs);
      end
      checks++;
      if (hold_cnt == 0 || stab_viol != 0) begin
         errors++;
         $display("FAIL bp_addr_hold holds=%0d violations=%0d required >0 0", hold_cnt, stab_viol);
      end
      checks++;
      if (data_out !== exp_data(8'hFF, 16'h0030)) begin
         errors++;
         $display("FAIL bp_data got %h required %h", data_out, exp_data(8'hFF, 16'h0030));
      end
      take_out();
   endtask

   task automatic test_empty();
      lat = 1;
      clr_log();
      do_req(8'h00, 16'h0070);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || mask_out !== 8'h00) begin
         errors++;
         $display("FAIL empty_first ov=%b mask=%h required 1 00", out_valid, mask_out);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, req_ready, mem_ren, mask_out} !== {1'b1, 1'b0, 1'b0, 8'h00}
             || data_out !== '0) begin
            errors++;
            $display("FAIL empty_hold[%0d] ov=%b rdy=%b ren=%b mask=%h required 1 0 0 00",
                     i, out_valid, req_ready, mem_ren, mask_out);
         end
      end
      checks++;
      if (iss_log.size() != 0) begin
         errors++;
         $display("FAIL empty_no_issue got %0d required 0", iss_log.size());
      end
      take_out();
   endtask

   task automatic test_reset_mid();
      int oc;
      bit ok;
      lat = 6;
      clr_log();
      do_req(8'h03, 16'h0040);
      repeat (3) @(negedge clk);
      checks++;
      if (iss_log.size() != 2 || mem_ren !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_drain issued=%0d ren=%b required 2 0", iss_log.size(), mem_ren);
      end
      #1;
      nrst = 1'b0;
      #1;
      checks++;
      if ({req_ready, mem_ren, mem_addr, out_valid, mask_out} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}
          || data_out !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs rdy=%b ren=%b addr=%h ov=%b mask=%h required 1 0 0 0 0",
                  req_ready, mem_ren, mem_addr, out_valid, mask_out);
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, out_valid, mem_ren, mask_out} !== {1'b1, 1'b0, 1'b0, 8'h0}
          || data_out !== '0) begin
         errors++;
         $display("FAIL rst_mid_stray rdy=%b ov=%b ren=%b data=%h required 1 0 0 0",
                  req_ready, out_valid, mem_ren, data_out);
      end
      lat = 2;
      clr_log();
      do_req(8'h0F, 16'h0050);
      wait_out(oc, ok);
      checks++;
      if (!ok || data_out !== exp_data(8'h0F, 16'h0050) || mask_out !== 8'h0F) begin
         errors++;
         $display("FAIL rst_mid_next got %h/%h ok=%0d required %h/0f",
                  data_out, mask_out, ok, exp_data(8'h0F, 16'h0050));
      end
      take_out();
   endtask

   task automatic test_spurious();
      int oc;
      bit ok;
      @(posedge clk);
      #1;
      inject = 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, out_valid, mem_ren, mask_out} !== {1'b1, 1'b0, 1'b0, 8'h0F}
          || data_out !== exp_data(8'h0F, 16'h0050)) begin
         errors++;
         $display("FAIL spurious_idle rdy=%b ov=%b ren=%b mask=%h data=%h required 1 0 0 0f %h",
                  req_ready, out_valid, mem_ren, mask_out, data_out, exp_data(8'h0F, 16'h0050));
      end
      lat = 1;
      clr_log();
      do_req(8'h01, 16'h0060);
      wait_out(oc, ok);
      checks++;
      if (!ok || data_out !== exp_data(8'h01, 16'h0060) || mask_out !== 8'h01) begin
         errors++;
         $display("FAIL spurious_next got %h/%h ok=%0d required %h/01",
                  data_out, mask_out, ok, exp_data(8'h01, 16'h0060));
      end
      take_out();
   endtask

   initial begin
      nrst      = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_mask  = '0;
      out_ready = 1'b0;
      test_reset();
      test_full();
      test_sparse();
      test_backpressure();
      test_empty();
      test_reset_mid();
      test_spurious();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
